tuple_regfile: RTL
==================

Name: tuple_regfile

Overview:
- Parametrised successor to the team's combinational 8x4 tuple array: DEPTH x WIDTH register file with per-entry valid bits.
- Two write ports, NRD registered read ports and a one-cycle bulk clear.
- Unwritten or cleared entries read as zero, the same default-zero tuple semantics as before, but storage now persists across cycles.
- Used as a test block for the yosys front-end flow (parametrised memories, multi-port write conflicts, packed port buses).

Parameters:
- WIDTH, 4, data bits per entry (>=1)
- DEPTH, 8, number of entries (>=2, need not be a power of 2)
- NRD, 2, number of read ports (>=1)
- AW, $clog2(DEPTH), address width (derived, localparam)

Ports:
- clk  input  1  clock, all state updates on rising edge
- reset_n  input  1  asynchronous active-low reset
- we0  input  1  write enable, port 0
- waddr0  input  AW  write address, port 0
- din0  input  WIDTH  write data, port 0
- we1  input  1  write enable, port 1 (priority port)
- waddr1  input  AW  write address, port 1
- din1  input  WIDTH  write data, port 1
- clear  input  1  invalidate all entries
- raddr  input  NRD*AW  packed read addresses; port k = raddr[k*AW +: AW]
- q  output  NRD*WIDTH  packed registered read data
- q_valid  output  NRD  per-port valid of registered read data
- occupancy  output  AW+1  count of valid entries

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-low, reset_n.
- Reset (reset_n=0, asynchronous): all entry data=0, all valid=0, q=0, q_valid=0, occupancy=0. Held while reset_n=0.
- Reset deasserted mid-operation: any in-flight write or read is lost. First edge after release behaves as a normal cycle.
- Write, port p: if wep=1 and waddrp<DEPTH, entry data<=dinp and valid<=1 at the edge.
- Write to an address >=DEPTH: ignored, no state change.
- Same-address write collision (we0=we1=1, waddr0==waddr1): port 1 wins; din0 discarded.
- Different addresses: both writes commit.
- clear=1: all valid<=0 at the edge, data unchanged.
- clear plus write in the same cycle: clear applies first, then writes. Written entries end valid with new data; every other entry is invalid.
- Read, port k: 1-cycle latency. At edge t, q[k]<=(valid[a] ? data[a] : 0) and q_valid[k]<=valid[a], where a=raddr[k] sampled at t.
- Read with a>=DEPTH: q[k]<=0, q_valid[k]<=0.
- Read ports are fully independent; any ports may share an address.
- Read/write same address, same cycle (no bypass): read returns pre-edge contents (old data/valid).
- Read/clear same cycle (no bypass): read returns pre-clear contents.
- occupancy: registered popcount of valid bits after the edge's updates.
  - Range 0..DEPTH.
  - Overwriting an already-valid entry does not change it.
  - Collision on one address counts as one entry.

Optional Feature:
- Macro: TUPLE_REGFILE_BYPASS_EN.
- Defined: write-to-read forwarding. A read whose address matches an active in-range write in the same cycle returns that write's data with q_valid=1 (port 1 data on collision).
- Defined, clear=1 with no matching write: read returns 0/q_valid=0.
- Not defined: reads return pre-edge state as above.
- Latency is 1 cycle either way.

Test Plan:
- Reset then read all 8 addresses on both ports -> q=0, q_valid=0 each cycle, occupancy=0.
- we0=1 waddr0=3 din0=4'hA; next cycle raddr port0=3 -> following cycle q[3:0]=4'hA, q_valid[0]=1, occupancy=1.
- we0=we1=1, waddr0=waddr1=5, din0=4'h1, din1=4'h2; then read 5 -> q=4'h2, occupancy=1.
- Fill entries 0..7, then clear=1 together with we0 to addr 2 (din0=4'h7) -> occupancy=1; read 2 -> 4'h7 valid; read 6 -> 0 invalid.
- Same-cycle write addr 4 (din=4'hC, entry previously 4'h9 valid) and read addr 4 -> q=4'h9 without macro, 4'hC with TUPLE_REGFILE_BYPASS_EN.
- Assert reset_n=0 asynchronously between edges while occupancy=5 -> q, q_valid, occupancy go 0 immediately, without waiting for an edge; all reads invalid after release.

Source files
------------

// File: rtl/tuple_regfile.sv
// DEPTH x WIDTH register file with per-entry valid bits, two write ports (port 1 wins
// collisions), NRD registered read ports, bulk clear and occupancy count. Optional macro
// TUPLE_REGFILE_BYPASS_EN forwards same-cycle write data to matching reads.
module tuple_regfile #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned NRD   = 2
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            we0,
    input  logic [$clog2(DEPTH)-1:0]        waddr0,
    input  logic [WIDTH-1:0]                din0,
    input  logic                            we1,
    input  logic [$clog2(DEPTH)-1:0]        waddr1,
    input  logic [WIDTH-1:0]                din1,
    input  logic                            clear,
    input  logic [NRD*$clog2(DEPTH)-1:0]    raddr,
    output logic [NRD*WIDTH-1:0]            q,
    output logic [NRD-1:0]                  q_valid,
    output logic [$clog2(DEPTH):0]          occupancy
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0]     r_data [DEPTH];
    logic [DEPTH-1:0]     r_valid;
    logic [NRD*WIDTH-1:0] r_q;
    logic [NRD-1:0]       r_q_valid;
    logic [CW-1:0]        r_occ;

    logic                 w_wr0;
    logic                 w_wr1;
    logic [DEPTH-1:0]     w_valid_nxt;
    logic [CW-1:0]        w_occ_nxt;
    logic [NRD*WIDTH-1:0] w_q_nxt;
    logic [NRD-1:0]       w_qv_nxt;
    logic [AW-1:0]        w_ra [NRD];

    assign w_wr0 = we0 && (32'(waddr0) < DEPTH);
    assign w_wr1 = we1 && (32'(waddr1) < DEPTH);

    // Next valid vector: clear first, then both writes; popcount of the result.
    always_comb begin
        w_valid_nxt = clear ? '0 : r_valid;
        if (w_wr0) w_valid_nxt[waddr0] = 1'b1;
        if (w_wr1) w_valid_nxt[waddr1] = 1'b1;
        w_occ_nxt = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            w_occ_nxt = w_occ_nxt + CW'(w_valid_nxt[i]);
        end
    end

    // Read data selection per port; invalid or out-of-range entries read as zero.
    always_comb begin
        w_q_nxt  = '0;
        w_qv_nxt = '0;
        for (int unsigned k = 0; k < NRD; k++) begin
            w_ra[k] = raddr[k*AW +: AW];
            if ((32'(w_ra[k]) < DEPTH) && r_valid[w_ra[k]]) begin
                w_q_nxt[k*WIDTH +: WIDTH] = r_data[w_ra[k]];
                w_qv_nxt[k]               = 1'b1;
            end
`ifdef TUPLE_REGFILE_BYPASS_EN
            if (w_wr1 && (w_ra[k] == waddr1)) begin
                w_q_nxt[k*WIDTH +: WIDTH] = din1;
                w_qv_nxt[k]               = 1'b1;
            end else if (w_wr0 && (w_ra[k] == waddr0)) begin
                w_q_nxt[k*WIDTH +: WIDTH] = din0;
                w_qv_nxt[k]               = 1'b1;
            end else if (clear) begin
                w_q_nxt[k*WIDTH +: WIDTH] = '0;
                w_qv_nxt[k]               = 1'b0;
            end
`endif
        end
    end

    // Entry storage; clear leaves data untouched since valid gates every read.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_data[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (w_wr1 && (32'(waddr1) == i)) begin
                    r_data[i] <= din1;
                end else if (w_wr0 && (32'(waddr0) == i)) begin
                    r_data[i] <= din0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid   <= '0;
            r_q       <= '0;
            r_q_valid <= '0;
            r_occ     <= '0;
        end else begin
            r_valid   <= w_valid_nxt;
            r_q       <= w_q_nxt;
            r_q_valid <= w_qv_nxt;
            r_occ     <= w_occ_nxt;
        end
    end

    assign q         = r_q;
    assign q_valid   = r_q_valid;
    assign occupancy = r_occ;

endmodule
